// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM
// Optional feature macro: MEM_ARBITER_RR_EN (round-robin tie-break; fixed port-0 priority when undefined)
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m0_cmd,
  input  logic [1:0]  m1_cmd,
  input  logic [8:0]  m0_addr,
  input  logic [8:0]  m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [15:0] m0_rdata,
  output logic [15:0] m1_rdata,
  output logic        m_err,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic        ram_re,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t      state_q, state_d;
  logic        req0, req1, any_req, win;
  logic        lat_id;
  logic [1:0]  lat_cmd;
  logic [8:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] cap_data;
  logic        in_range, access, done;

  // Reserved (11) and idle (00) commands never count as requests.
  assign req0    = (m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE);
  assign req1    = (m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE);
  assign any_req = req0 || req1;

`ifdef MEM_ARBITER_RR_EN
  logic last_grant;

  assign win = (req0 && req1) ? ~last_grant : req1;

  // Remember who was served last so a tie goes to the other port; port 1 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_grant <= win;
    end
  end
`else
  assign win = req1 && !req0;
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fixed four-state walk: every transaction takes the same number of cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request in IDLE and capture RAM read data on leaving WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_id    <= 1'b0;
      lat_cmd   <= 2'b00;
      lat_addr  <= 9'h000;
      lat_wdata <= 16'h0000;
      cap_data  <= 16'h0000;
    end else begin
      if (state_q == IDLE && any_req) begin
        lat_id    <= win;
        lat_cmd   <= win ? m1_cmd   : m0_cmd;
        lat_addr  <= win ? m1_addr  : m0_addr;
        lat_wdata <= win ? m1_wdata : m0_wdata;
      end
      if (state_q == WAIT) begin
        cap_data <= (lat_cmd == CMD_READ && !lat_addr[8]) ? ram_rdata : 16'h0000;
      end
    end
  end

  assign in_range  = !lat_addr[8];
  assign access    = (state_q == ACCESS) && in_range;
  assign done      = (state_q == DONE);

  assign ram_addr  = access ? lat_addr[7:0] : 8'h00;
  assign ram_wdata = access ? lat_wdata : 16'h0000;
  assign ram_we    = access && (lat_cmd == CMD_WRITE);
  assign ram_re    = access && (lat_cmd == CMD_READ);

  assign m0_ack    = done && !lat_id;
  assign m1_ack    = done && lat_id;
  assign m0_rdata  = m0_ack ? cap_data : 16'h0000;
  assign m1_rdata  = m1_ack ? cap_data : 16'h0000;
  assign m_err     = done && lat_addr[8];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  m0_cmd = 2'b00, m1_cmd = 2'b00;
  logic [8:0]  m0_addr = 9'h000, m1_addr = 9'h000;
  logic [15:0] m0_wdata = 16'h0000, m1_wdata = 16'h0000;
  logic        m0_ack, m1_ack, m_err, ram_we, ram_re, busy;
  logic [15:0] m0_rdata, m1_rdata, ram_wdata;
  logic [15:0] ram_rdata = 16'h0000;
  logic [7:0]  ram_addr;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m1_cmd(m1_cmd),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m_err(m_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous write, registered read.
  logic [15:0] env_mem [0:255];
  always @(posedge clk) begin
    if (ram_we) env_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= env_mem[ram_addr];
  end

  typedef struct {int id; logic [15:0] data; logic err; int cyc;} ack_t;
  typedef struct {logic we; logic [7:0] addr; logic [15:0] wdata; int cyc;} stb_t;

  ack_t        ack_q[$];
  stb_t        stb_q[$];
  int          obs_ids[$];
  logic [15:0] ref_mem [0:255];
  int          ref_last = 1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ack_t        ea;
  stb_t        es;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack and every RAM strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      obs_ids.push_back(m1_ack ? 1 : 0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      end else begin
        ea = ack_q.pop_front();
        chk("ack_id", {30'd0, m1_ack, m0_ack}, ea.id != 0 ? 32'd2 : 32'd1);
        chk("ack_cycle", cyc, ea.cyc);
        chk("rdata", ea.id != 0 ? m1_rdata : m0_rdata, ea.data);
        chk("other_rdata", ea.id != 0 ? m0_rdata : m1_rdata, 32'd0);
        chk("m_err", m_err, ea.err);
      end
    end else if (m_err) begin
      chk("err_without_ack", m_err, 32'd0);
    end
    if (ram_we || ram_re) begin
      if (stb_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, ram_we, ram_re}, 32'd0);
      end else begin
        es = stb_q.pop_front();
        chk("strobe_kind", {30'd0, ram_we, ram_re}, es.we ? 32'd2 : 32'd1);
        chk("strobe_addr", ram_addr, es.addr);
        if (es.we) chk("strobe_wdata", ram_wdata, es.wdata);
        chk("strobe_cycle", cyc, es.cyc);
      end
    end
  end

  // One arbitration round: called at a negedge with the DUT idle, returns at a negedge with it idle.
  task automatic round(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                       input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1,
                       input bit junk);
    bit r0, r1;
    int w, kc;
    logic [1:0] wc;
    logic [8:0] wa;
    logic [15:0] wd, exp_data;
    r0 = (c0 == 2'b01) || (c0 == 2'b10);
    r1 = (c1 == 2'b01) || (c1 == 2'b10);
    m0_cmd = c0; m0_addr = a0; m0_wdata = d0;
    m1_cmd = c1; m1_addr = a1; m1_wdata = d1;
    @(posedge clk);
    #1;
    kc = cyc;
    if (!r0 && !r1) begin
      @(negedge clk);
      chk("idle_busy", busy, 32'd0);
      return;
    end
`ifdef MEM_ARBITER_RR_EN
    w = (r0 && r1) ? 1 - ref_last : (r1 ? 1 : 0);
`else
    w = r0 ? 0 : 1;
`endif
    ref_last = w;
    wc = w != 0 ? c1 : c0;
    wa = w != 0 ? a1 : a0;
    wd = w != 0 ? d1 : d0;
    exp_data = 16'h0000;
    if (!wa[8]) begin
      stb_q.push_back('{we: (wc == 2'b10), addr: wa[7:0], wdata: wd, cyc: kc});
      if (wc == 2'b10) ref_mem[wa[7:0]] = wd;
      else exp_data = ref_mem[wa[7:0]];
    end
    ack_q.push_back('{id: w, data: exp_data, err: wa[8], cyc: kc + 2});
    if (junk) begin
      m0_cmd = 2'($urandom_range(0, 3)); m0_addr = 9'($urandom); m0_wdata = 16'($urandom);
      m1_cmd = 2'($urandom_range(0, 3)); m1_addr = 9'($urandom); m1_wdata = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [8:0] ra0, ra1;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_err", m_err, 32'd0);
    chk("rst_strobes", {30'd0, ram_we, ram_re}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write then read back from port 0; out-of-range read from port 1
    round(2'b10, 9'h005, 16'hBEEF, 2'b00, 9'h000, 16'h0000, 1'b0);
    round(2'b01, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000, 1'b0);
    round(2'b00, 9'h000, 16'h0000, 2'b01, 9'h100, 16'h0000, 1'b0);

    // Both ports read continuously for three transactions
    n = obs_ids.size();
    for (int t = 0; t < 3; t++)
      round(2'b01, 9'h005, 16'h0000, 2'b01, 9'h006, 16'h0000, 1'b0);
    chk("tie_count", obs_ids.size() - n, 32'd3);
    if (obs_ids.size() - n == 3) begin
`ifdef MEM_ARBITER_RR_EN
      chk("tie_grant0", obs_ids[n], 32'd0);
      chk("tie_grant1", obs_ids[n+1], 32'd1);
      chk("tie_grant2", obs_ids[n+2], 32'd0);
`else
      chk("tie_grant0", obs_ids[n], 32'd0);
      chk("tie_grant1", obs_ids[n+1], 32'd0);
      chk("tie_grant2", obs_ids[n+2], 32'd0);
`endif
    end
    m0_cmd = 2'b00; m1_cmd = 2'b00;

    // Reserved command never starts a transaction
    m0_cmd = 2'b11;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reserved_busy", busy, 32'd0);
    end
    m0_cmd = 2'b00;

    // Reset during WAIT of a port-1 write: the write reached RAM, but no ack follows
    m1_cmd = 2'b10; m1_addr = 9'h020; m1_wdata = 16'h1234;
    @(posedge clk);
    #1;
    stb_q.push_back('{we: 1'b1, addr: 8'h20, wdata: 16'h1234, cyc: cyc});
    ref_mem[8'h20] = 16'h1234;
    m1_cmd = 2'b00;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", busy, 32'd0);
    @(negedge clk);
    chk("rst_no_ack", m1_ack, 32'd0);
    reset = 1'b1;
    ref_last = 1;
    round(2'b01, 9'h020, 16'h0000, 2'b00, 9'h000, 16'h0000, 1'b0);

    // Randomised traffic with junk inputs while busy
    for (int t = 0; t < 80; t++) begin
      ra0 = 9'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 9'h100 : 9'h000);
      ra1 = 9'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 9'h100 : 9'h000);
      round(2'($urandom_range(0, 3)), ra0, 16'($urandom),
            2'($urandom_range(0, 3)), ra1, 16'($urandom), 1'b1);
    end
    m0_cmd = 2'b00; m1_cmd = 2'b00;

    repeat (4) @(negedge clk);
    chk("ack_queue_drained", ack_q.size(), 32'd0);
    chk("strobe_queue_drained", stb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports m0_cmd and m1_cmd, input, 2 each, requester command: 00 none, 01 read, 10 write, 11 reserved.
REQ-004 SHALL have ports m0_addr and m1_addr, input, 9 each, word address; bit 8 = 1 is out-of-range.
REQ-005 SHALL have ports m0_wdata and m1_wdata, input, 16 each, write data.
REQ-006 SHALL have ports m0_ack and m1_ack, output, 1 each, one-cycle completion pulse.
REQ-007 SHALL have ports m0_rdata and m1_rdata, output, 16 each, read data, valid while the matching ack is high.
REQ-008 SHALL have port m_err, output, 1, high with an ack whose transaction was out-of-range.
REQ-009 SHALL have ports ram_addr (output, 8), ram_we (output, 1), ram_re (output, 1) and ram_wdata (output, 16), driving the single-port RAM.
REQ-010 SHALL have port ram_rdata, input, 16, RAM read data, valid the cycle after a ram_re cycle.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WAIT and DONE; all outputs are registered or decoded from state only.
REQ-013 In IDLE, a port SHALL be requesting when its cmd is 01 or 10; cmd 00 and cmd 11 SHALL be ignored.
REQ-014 SHALL, at the edge where IDLE sees at least one request, latch the winner's id, cmd, addr and wdata, and enter ACCESS.
REQ-015 SHALL, on a simultaneous request, grant the port not granted last (round-robin); a sole requester always wins.
REQ-016 In ACCESS, for an in-range transaction, SHALL drive ram_addr = latched addr[7:0] and ram_wdata = latched wdata, with exactly one of ram_we or ram_re high according to cmd.
REQ-017 ACCESS SHALL go to WAIT unconditionally; ram_we and ram_re SHALL be low in every state except ACCESS.
REQ-018 At the WAIT-to-DONE edge, SHALL capture ram_rdata for an in-range read, and 16'h0000 for writes and out-of-range transactions.
REQ-019 In DONE, SHALL assert only the winner's ack for exactly one cycle, present the captured data on its rdata, and go to IDLE.
REQ-020 The non-winner's rdata SHALL read 16'h0000 and its ack SHALL stay low.
REQ-021 Latency SHALL be fixed: the request is sampled at edge k, and ack is high in the cycle following edge k+2.
REQ-022 For an out-of-range transaction (addr[8] = 1), SHALL keep ram strobes low, use the same latency, and assert m_err together with ack.
REQ-023 SHALL treat a cmd still held in the cycle after DONE as a new transaction; the arbiter SHALL ignore request changes while busy.

Reset
REQ-024 On reset low, SHALL immediately enter IDLE, abandoning any in-flight transaction, with no ack ever issued for it.
REQ-025 On reset low, all outputs SHALL be 0 (acks, m_err, busy, ram strobes, ram_addr, ram_wdata, rdata).
REQ-026 On reset low, last-grant SHALL be set to port 1, so port 0 wins the first tie.

Configuration
REQ-027 With macro MEM_ARBITER_RR_EN defined, tie-breaking SHALL be round-robin per REQ-015.
REQ-028 Without MEM_ARBITER_RR_EN, port 0 SHALL always win ties (fixed priority) and the last-grant register SHALL be omitted.

Verification
REQ-029 m0 write addr 9'h005 data 16'hBEEF -> ram_we high with ram_addr 8'h05 and ram_wdata 16'hBEEF exactly one cycle; m0_ack pulses at edge k+2; m0_rdata 16'h0000.
REQ-030 m0 read 9'h005 after REQ-029 -> m0_rdata 16'hBEEF with m0_ack one cycle; m1_ack stays 0.
REQ-031 m0 and m1 both read, held through three transactions, with RR_EN -> grants m0, m1, m0; without RR_EN -> grants m0, m0, m0.
REQ-032 m1 read 9'h100 -> no ram_re; m1_ack and m_err high together at edge k+2; m1_rdata 16'h0000.
REQ-033 reset low during WAIT of m1 write -> busy 0 asynchronously; no m1_ack; next m0 request completes normally.
REQ-034 m0_cmd 2'b11 held 5 cycles -> busy stays 0 and no RAM strobes.
